reaction_timer: RTL and testbench



---
 rtl/reaction_pkg.sv | 39 +++
 rtl/ms_tick_gen.sv | 28 ++
 rtl/reaction_timer.sv | 156 +++++++++++++++
 tb/tb_reaction_timer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer: FSM states, LFSR seed/taps
// and packed BCD digit types with a saturating increment helper.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DELAY,
    STIMULUS,
    DONE,
    FAULT
  } rt_state_t;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [3:0] bcd_word_t;

  function automatic bcd_word_t bcd_inc(input bcd_word_t v);
    bcd_word_t r;
    logic      carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = r[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and raises tick for the last count.
// A synchronous clear restarts the count so the next ms is a full one.
module ms_tick_gen #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer core: random pre-delay, stimulus drive, ms reaction measurement.
// Optional BCD copy of the result when REACT_BCD_EN is defined.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int DELAY_BITS   = 11,
  parameter int MAX_MS       = 9999,
  parameter int MS_W         = 14
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_sustain,
  input  logic            react_sustain,
  output logic            stimulus,
  output logic [MS_W-1:0] result_ms,
  output logic            result_valid,
  output logic            false_start,
  output logic            timeout,
  output logic            busy
`ifdef REACT_BCD_EN
  ,
  output logic [15:0]     result_bcd
`endif
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam logic [MS_W-1:0] MAX_CNT = MS_W'(MAX_MS);

  rt_state_t       state;
  logic [15:0]     lfsr;
  logic            start_prev, react_prev, start_arm, react_arm;
  logic            start_edge, react_edge;
  logic [MS_W-1:0] ms_cnt, ms_inc, delay_target;
  logic            tick, tick_clr, idle_like;
  logic            start_go, wait_react, delay_done, stim_react, stim_max;

  function automatic logic [MS_W-1:0] sat_ms(input logic [MS_W-1:0] v);
    return (v > MAX_CNT) ? MAX_CNT : v;
  endfunction

  // An arm bit keeps a level that was already high at reset release from counting as an edge
  assign start_edge = start_sustain & ~start_prev & start_arm;
  assign react_edge = react_sustain & ~react_prev & react_arm;

  assign ms_inc     = ms_cnt + {{(MS_W-1){1'b0}}, tick};
  assign idle_like  = (state == IDLE) || (state == DONE) || (state == FAULT);
  assign start_go   = idle_like && start_edge;
  assign wait_react = (state == WAIT_DELAY) && react_edge;
  assign delay_done = (state == WAIT_DELAY) && tick && (ms_inc >= delay_target);
  assign stim_react = (state == STIMULUS) && react_edge;
  assign stim_max   = (state == STIMULUS) && tick && (ms_inc >= MAX_CNT);
  assign tick_clr   = start_go || wait_react || delay_done || stim_react || stim_max;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(tick_clr),
    .tick (tick)
  );

`ifdef REACT_BCD_EN
  bcd_word_t bcd_cnt, bcd_next;
  assign bcd_next = tick ? bcd_inc(bcd_cnt) : bcd_cnt;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      start_prev   <= 1'b0;
      react_prev   <= 1'b0;
      start_arm    <= 1'b0;
      react_arm    <= 1'b0;
      ms_cnt       <= '0;
      delay_target <= '0;
      stimulus     <= 1'b0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
`ifdef REACT_BCD_EN
      bcd_cnt      <= '0;
      result_bcd   <= '0;
`endif
    end else begin
      lfsr       <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      start_prev <= start_sustain;
      react_prev <= react_sustain;
      start_arm  <= start_arm | ~start_sustain;
      react_arm  <= react_arm | ~react_sustain;

      case (state)
        IDLE, DONE, FAULT: begin
          if (start_go) begin
            state        <= WAIT_DELAY;
            busy         <= 1'b1;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            result_ms    <= '0;
            delay_target <= MS_W'(MIN_DELAY_MS) + MS_W'(lfsr[DELAY_BITS-1:0]);
            ms_cnt       <= '0;
`ifdef REACT_BCD_EN
            result_bcd   <= '0;
`endif
          end
        end

        WAIT_DELAY: begin
          // A reaction coinciding with delay expiry still counts as a false start
          if (wait_react) begin
            state       <= FAULT;
            false_start <= 1'b1;
            busy        <= 1'b0;
          end else if (delay_done) begin
            state    <= STIMULUS;
            stimulus <= 1'b1;
            ms_cnt   <= '0;
`ifdef REACT_BCD_EN
            bcd_cnt  <= '0;
`endif
          end else begin
            ms_cnt <= ms_inc;
          end
        end

        STIMULUS: begin
          if (stim_react || stim_max) begin
            state        <= DONE;
            stimulus     <= 1'b0;
            busy         <= 1'b0;
            result_ms    <= sat_ms(ms_inc);
            result_valid <= stim_react;
            timeout      <= ~stim_react;
`ifdef REACT_BCD_EN
            result_bcd   <= bcd_next;
`endif
          end else begin
            ms_cnt <= ms_inc;
`ifdef REACT_BCD_EN
            bcd_cnt <= bcd_next;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Randomized scoreboard bench for reaction_timer (small clock so 1 ms = 10 cycles).
// Define REACT_BCD_EN for both bench and design to also check result_bcd.
module tb_reaction_timer;

  localparam int CLK_HZ   = 10_000;
  localparam int TICK     = 10;
  localparam int MIN_MS   = 5;
  localparam int MAX_MS   = 50;
  localparam int MS_W     = 14;

  typedef struct {
    int end_cyc;
    int ms;
    bit fs;
    bit valid;
    bit to;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_sustain = 1'b0;
  logic react_sustain = 1'b0;
  logic stimulus, result_valid, false_start, timeout, busy;
  logic [MS_W-1:0] result_ms;
`ifdef REACT_BCD_EN
  logic [15:0] result_bcd;
`endif

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [15:0] m_lfsr;
  exp_t exp_q[$];
  int   stim_q[$];

  reaction_timer #(
    .CLK_HZ(CLK_HZ),
    .MIN_DELAY_MS(MIN_MS),
    .DELAY_BITS(3),
    .MAX_MS(MAX_MS),
    .MS_W(MS_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start_sustain(start_sustain),
    .react_sustain(react_sustain),
    .stimulus     (stimulus),
    .result_ms    (result_ms),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timeout      (timeout),
    .busy         (busy)
`ifdef REACT_BCD_EN
    ,
    .result_bcd   (result_bcd)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference pseudo-random source: x^16+x^14+x^13+x^11+1, shifted in at bit 0
  always @(posedge clock or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations when the stimulus rises and when a trial ends
  initial begin
    bit   pb, ps;
    exp_t e;
    pb = 1'b0;
    ps = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pb = 1'b0;
        ps = 1'b0;
      end else begin
        if (stimulus && !ps) begin
          if (stim_q.size() == 0) check("stim_rise_unexpected", cyc, -1);
          else begin
            check("stim_rise_cycle", cyc, stim_q.pop_front());
            check("busy_at_stim", int'(busy), 1);
          end
        end
        if (!busy && pb) begin
          if (exp_q.size() == 0) check("trial_end_unexpected", cyc, -1);
          else begin
            e = exp_q.pop_front();
            check("end_cycle", cyc, e.end_cyc);
            check("false_start", int'(false_start), int'(e.fs));
            check("result_valid", int'(result_valid), int'(e.valid));
            check("timeout", int'(timeout), int'(e.to));
            check("stimulus_low", int'(stimulus), 0);
            if (!e.fs) begin
              check("result_ms", int'(result_ms), e.ms);
`ifdef REACT_BCD_EN
              check("result_bcd", int'(result_bcd), to_bcd(e.ms));
`endif
            end
          end
        end
        pb = busy;
        ps = stimulus;
      end
    end
  end

  // mode: 0 react in delay, 1 react k cycles after stimulus, 2 react at expiry,
  // 3 react at MAX_MS, 4 no react, 5 react 1 cycle after stimulus, 6 react with start
  task automatic run_trial(input int mode, input int k, input bit restart_mid);
    exp_t e;
    int   ns, d, m, ev, last, kk;
    repeat (3) @(negedge clock);
    ns = cyc + 1;
    d  = MIN_MS + int'(m_lfsr[2:0]);
    m  = ns + TICK * d;
    kk = k;
    case (mode)
      0: begin
        if (kk <= 0) kk = int'($urandom_range(1, TICK * d - 1));
        ev = ns + kk;
      end
      1: begin
        if (kk <= 0) kk = int'($urandom_range(1, TICK * MAX_MS - 1));
        ev = m + kk;
      end
      2: ev = m;
      3: ev = m + TICK * MAX_MS;
      5: ev = m + 1;
      default: ev = -1;
    endcase
    e.fs = 1'b0; e.valid = 1'b0; e.to = 1'b0; e.ms = 0;
    if (ev >= 0 && ev <= m) begin
      e.fs = 1'b1;
      e.end_cyc = ev;
    end else if (ev >= 0 && ev <= m + TICK * MAX_MS) begin
      e.valid = 1'b1;
      e.ms = (ev - m) / TICK;
      e.end_cyc = ev;
    end else begin
      e.to = 1'b1;
      e.ms = MAX_MS;
      e.end_cyc = m + TICK * MAX_MS;
    end
    if (!e.fs) stim_q.push_back(m);
    exp_q.push_back(e);
    last = e.end_cyc;
    start_sustain = 1'b1;
    react_sustain = (mode == 6);
    while (cyc < last + 2) begin
      @(negedge clock);
      start_sustain = restart_mid && (cyc + 1 >= m + 5) && (cyc + 1 < m + 7);
      react_sustain = (cyc + 1 == ev);
    end
    start_sustain = 1'b0;
    react_sustain = 1'b0;
  endtask

  task automatic reset_mid_trial();
    int ns, m;
    repeat (3) @(negedge clock);
    ns = cyc + 1;
    m  = ns + TICK * (MIN_MS + int'(m_lfsr[2:0]));
    stim_q.push_back(m);
    start_sustain = 1'b1;
    @(negedge clock);
    start_sustain = 1'b0;
    while (cyc < m + 30) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_stimulus", int'(stimulus), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(result_valid), 0);
    check("rst_false_start", int'(false_start), 0);
    check("rst_timeout", int'(timeout), 0);
    @(negedge clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    start_sustain = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_stimulus", int'(stimulus), 0);
    check("reset_result_ms", int'(result_ms), 0);
    check("reset_valid", int'(result_valid), 0);
    check("reset_false_start", int'(false_start), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_busy", int'(busy), 0);
    #2 reset = 1'b0;
    repeat (6) @(negedge clock);
    check("held_start_no_edge", int'(busy), 0);
    start_sustain = 1'b0;

    run_trial(1, TICK * 12 + 3, 1'b0);
    run_trial(0, TICK * 2, 1'b0);
    run_trial(4, 0, 1'b0);
    run_trial(1, TICK * 3 + 5, 1'b1);
    reset_mid_trial();
    run_trial(1, TICK * 37 + 5, 1'b0);
    run_trial(2, 0, 1'b0);
    run_trial(3, 0, 1'b0);
    run_trial(5, 0, 1'b0);
    run_trial(6, 0, 1'b0);
    for (int t = 0; t < 14; t++) run_trial(int'($urandom_range(0, 6)), 0, 1'b0);

    for (int i = 0; i < 200 && (exp_q.size() != 0 || stim_q.size() != 0); i++) @(negedge clock);
    check("pending_expectations", exp_q.size() + stim_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
